// File: rtl/l2_inv_ack_collector_if.sv
// Handshake, NoC message and line-status bundle of the L2 invalidation-ack collector.
// slave = collector side; master = directory pipeline / NoC side.
// Latency: none (signal bundle only); backpressure: carried by the start/msg3/msg2 valid-ready pairs.
interface l2_inv_ack_collector_if #(
    parameter int NUM_SHARERS = 64,
    parameter int TAG_W       = 26,
    parameter int SRC_W       = 6,
    parameter int TYPE_W      = 8,
    parameter int CNT_W       = 8
);
    logic                   start_valid;
    logic                   start_ready;
    logic [TAG_W-1:0]       start_tag;
    logic [SRC_W-1:0]       start_src;
    logic [NUM_SHARERS-1:0] start_share_list;

    logic                   msg3_valid;
    logic                   msg3_ready;
    logic [TYPE_W-1:0]      msg3_type;
    logic [SRC_W-1:0]       msg3_source;
    logic [TAG_W-1:0]       msg3_tag;

    logic                   msg2_valid;
    logic                   msg2_ready;
    logic [TYPE_W-1:0]      msg2_type;
    logic [SRC_W-1:0]       msg2_dest;
    logic [TAG_W-1:0]       msg2_tag;

    logic [1:0]             cache_state;
    logic [1:0]             cur_msg_state;
    logic [NUM_SHARERS-1:0] pending_list;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   stray_ack;
    logic                   timeout;

    modport master (
        output start_valid, start_tag, start_src, start_share_list,
        output msg3_valid, msg3_type, msg3_source, msg3_tag,
        output msg2_ready,
        input  start_ready, msg3_ready,
        input  msg2_valid, msg2_type, msg2_dest, msg2_tag,
        input  cache_state, cur_msg_state, pending_list, wait_cnt, stray_ack, timeout
    );

    modport slave (
        input  start_valid, start_tag, start_src, start_share_list,
        input  msg3_valid, msg3_type, msg3_source, msg3_tag,
        input  msg2_ready,
        output start_ready, msg3_ready,
        output msg2_valid, msg2_type, msg2_dest, msg2_tag,
        output cache_state, cur_msg_state, pending_list, wait_cnt, stray_ack, timeout
    );
endinterface

// File: rtl/l2_inv_ack_collector.sv
// Collects INV_FWDACKs for one L2 line invalidation round, then issues a msg2 completion.
// Latency: last matching ack -> msg2_valid 1 cycle; empty share list -> msg2_valid 1 cycle after start.
// Backpressure: msg3 always consumed in WAIT; msg2 held stable until msg2_ready. L2_INV_TIMEOUT_EN adds ERR completion.
module l2_inv_ack_collector #(
    parameter int                NUM_SHARERS = 64,
    parameter int                TAG_W       = 26,
    parameter int                SRC_W       = 6,
    parameter int                TYPE_W      = 8,
    parameter int                CNT_W       = 8,
    parameter logic [TYPE_W-1:0] ACK_TYPE    = 8'h17,
    parameter logic [TYPE_W-1:0] DONE_TYPE   = 8'h18,
    parameter logic [TYPE_W-1:0] ERR_TYPE    = 8'h1F,
    parameter int                TIMEOUT     = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_inv_ack_collector_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [1:0]       CS_INVALID  = 2'd0;
    localparam logic [1:0]       CS_TRANSIENT = 2'd3;

    state_e                 state_q, state_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [SRC_W-1:0]       src_q, src_d;
    logic [NUM_SHARERS-1:0] pend_q, pend_d;
    logic [1:0]             cache_q, cache_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stray_q, stray_d;
    logic                   err_q, err_d;

    logic src_in_range;
    logic ack_hit;
    logic cnt_sat;

    // Source ids above the share-list width can never match a sharer bit.
    assign src_in_range = int'(bus.msg3_source) < NUM_SHARERS;
    assign ack_hit      = (bus.msg3_type == ACK_TYPE) && (bus.msg3_tag == tag_q) &&
                          src_in_range && pend_q[bus.msg3_source];
    assign cnt_sat      = (cnt_q == CNT_MAX);

`ifdef L2_INV_TIMEOUT_EN
    logic tmo_q, tmo_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        src_d   = src_q;
        pend_d  = pend_q;
        cache_d = cache_q;
        cnt_d   = cnt_q;
        stray_d = 1'b0;
        err_d   = err_q;
`ifdef L2_INV_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    tag_d   = bus.start_tag;
                    src_d   = bus.start_src;
                    pend_d  = bus.start_share_list;
                    cache_d = CS_TRANSIENT;
                    cnt_d   = CNT_W'(1);
                    err_d   = 1'b0;
                    state_d = (|bus.start_share_list) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (bus.msg3_valid) begin
                    if (ack_hit) begin
                        pend_d[bus.msg3_source] = 1'b0;
                    end else begin
                        stray_d = 1'b1;
                    end
                end
`ifdef L2_INV_TIMEOUT_EN
                // A same-cycle ack is applied first; only sharers still missing force the error path.
                if ((cnt_q == CNT_W'(TIMEOUT)) && (|pend_d)) begin
                    tmo_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else
`endif
                begin
                    if (!cnt_sat) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (!(|pend_d)) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.msg2_ready) begin
                    cache_d = CS_INVALID;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            src_q   <= '0;
            pend_q  <= '0;
            cache_q <= CS_INVALID;
            cnt_q   <= '0;
            stray_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            cache_q <= cache_d;
            cnt_q   <= cnt_d;
            stray_q <= stray_d;
            err_q   <= err_d;
        end
    end

`ifdef L2_INV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign bus.timeout = tmo_q;
`else
    assign bus.timeout = 1'b0;
`endif

    // start_ready stays low while reset is held so a round cannot slip in during reset.
    assign bus.start_ready   = rst && (state_q == ST_IDLE);
    assign bus.msg3_ready    = (state_q == ST_WAIT);
    assign bus.msg2_valid    = (state_q == ST_RESP);
    assign bus.msg2_type     = (state_q == ST_RESP) ? (err_q ? ERR_TYPE : DONE_TYPE) : '0;
    assign bus.msg2_dest     = src_q;
    assign bus.msg2_tag      = tag_q;
    assign bus.cache_state   = cache_q;
    assign bus.cur_msg_state = state_q;
    assign bus.pending_list  = pend_q;
    assign bus.wait_cnt      = cnt_q;
    assign bus.stray_ack     = stray_q;

    a_msg2_hold: assert property (@(posedge clk) disable iff (!rst)
        (bus.msg2_valid && !bus.msg2_ready) |=>
            (bus.msg2_valid && $stable(bus.msg2_type) && $stable(bus.msg2_dest) && $stable(bus.msg2_tag)));

    a_chan_excl: assert property (@(posedge clk) disable iff (!rst)
        !(bus.msg3_ready && bus.msg2_valid));

    a_cnt_no_wrap: assert property (@(posedge clk) disable iff (!rst)
        (state_q != ST_IDLE) |=> (cnt_q >= $past(cnt_q)));

endmodule

// File: tb/tb_l2_inv_ack_collector.sv
// Self-checking bench for l2_inv_ack_collector: table-driven rounds plus hand-written corner sequences.
// msg2 completions are checked against a scoreboard queue filled when each round is started.
module tb_l2_inv_ack_collector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    l2_inv_ack_collector_if bus ();

    l2_inv_ack_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [7:0] ACK  = 8'h17;
    localparam logic [7:0] DONE = 8'h18;
    localparam logic [7:0] ERR  = 8'h1F;

    typedef struct {
        logic [7:0]  typ;
        logic [5:0]  dest;
        logic [25:0] tag;
    } exp_t;

    typedef struct {
        logic [63:0] share;
        logic [25:0] tag;
        logic [5:0]  src;
        logic [7:0]  exp_cnt;
    } vec_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] sh, input logic [25:0] tg, input logic [5:0] sr);
        bus.start_valid      = 1'b1;
        bus.start_share_list = sh;
        bus.start_tag        = tg;
        bus.start_src        = sr;
        tick();
        bus.start_valid      = 1'b0;
    endtask

    task automatic send_msg3(input logic [7:0] ty, input logic [5:0] sr, input logic [25:0] tg);
        bus.msg3_valid  = 1'b1;
        bus.msg3_type   = ty;
        bus.msg3_source = sr;
        bus.msg3_tag    = tg;
        tick();
        bus.msg3_valid  = 1'b0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, ".start_ready"}, 64'(bus.start_ready), 0);
        chk({pfx, ".msg3_ready"}, 64'(bus.msg3_ready), 0);
        chk({pfx, ".msg2_valid"}, 64'(bus.msg2_valid), 0);
        chk({pfx, ".msg2_type"}, 64'(bus.msg2_type), 0);
        chk({pfx, ".cache_state"}, 64'(bus.cache_state), 0);
        chk({pfx, ".cur_msg_state"}, 64'(bus.cur_msg_state), 0);
        chk({pfx, ".pending_list"}, bus.pending_list, 0);
        chk({pfx, ".wait_cnt"}, 64'(bus.wait_cnt), 0);
        chk({pfx, ".stray_ack"}, 64'(bus.stray_ack), 0);
        chk({pfx, ".timeout"}, 64'(bus.timeout), 0);
    endtask

    // Completion monitor: every handshake must match the oldest expected completion.
    always @(negedge clk) begin
        if (bus.msg2_valid && bus.msg2_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL msg2_unexpected: got type %0h dest %0h tag %0h, required none",
                         bus.msg2_type, bus.msg2_dest, bus.msg2_tag);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("msg2.type", 64'(bus.msg2_type), 64'(e.typ));
                chk("msg2.dest", 64'(bus.msg2_dest), 64'(e.dest));
                chk("msg2.tag", 64'(bus.msg2_tag), 64'(e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [63:0] exp_pend;
        logic [25:0] tg;
`ifdef L2_INV_TIMEOUT_EN
        localparam int SAT_CYC = 20;
`else
        localparam int SAT_CYC = 300;
`endif

        vecs[0] = '{64'h0000_0000_0000_0408, 26'h0ABCDEF, 6'd5,  8'd3};
        vecs[1] = '{64'h0000_0000_0000_0000, 26'h0000155, 6'd2,  8'd1};
        vecs[2] = '{64'h0000_0000_0000_0001, 26'h0000001, 6'd1,  8'd2};
        vecs[3] = '{64'h8000_0000_0000_0000, 26'h3FFFFFF, 6'd63, 8'd2};
        vecs[4] = '{64'h0000_0000_0000_000F, 26'h2AAAAAA, 6'd62, 8'd5};
        vecs[5] = '{64'h8000_0000_0000_0001, 26'h1234567, 6'd0,  8'd3};

        bus.start_valid      = 1'b0;
        bus.start_tag        = '0;
        bus.start_src        = '0;
        bus.start_share_list = '0;
        bus.msg3_valid       = 1'b0;
        bus.msg3_type        = '0;
        bus.msg3_source      = '0;
        bus.msg3_tag         = '0;
        bus.msg2_ready       = 1'b1;

        // Reset state
        #2;
        chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst.release.start_ready", 64'(bus.start_ready), 1);

        // Table-driven rounds; acks sent highest sharer first
        for (int r = 0; r < 6; r++) begin
            exp_pend = vecs[r].share;
            chk("row.start_ready", 64'(bus.start_ready), 1);
            sb_q.push_back('{DONE, vecs[r].src, vecs[r].tag});
            do_start(vecs[r].share, vecs[r].tag, vecs[r].src);
            chk("row.cache_transient", 64'(bus.cache_state), 3);
            chk("row.cnt_start", 64'(bus.wait_cnt), 1);
            chk("row.pend_latched", bus.pending_list, vecs[r].share);
            for (int b = 63; b >= 0; b--) begin
                if (exp_pend[b]) begin
                    chk("row.wait_state", 64'(bus.cur_msg_state), 1);
                    chk("row.msg3_ready", 64'(bus.msg3_ready), 1);
                    send_msg3(ACK, 6'(b), vecs[r].tag);
                    exp_pend[b] = 1'b0;
                    chk("row.ack_pend", bus.pending_list, exp_pend);
                    chk("row.no_stray", 64'(bus.stray_ack), 0);
                end
            end
            chk("row.resp_state", 64'(bus.cur_msg_state), 2);
            chk("row.msg2_valid", 64'(bus.msg2_valid), 1);
            chk("row.resp_msg3_ready", 64'(bus.msg3_ready), 0);
            chk("row.resp_cnt", 64'(bus.wait_cnt), 64'(vecs[r].exp_cnt));
            tick();
            chk("row.idle_state", 64'(bus.cur_msg_state), 0);
            chk("row.cache_invalid", 64'(bus.cache_state), 0);
            chk("row.idle_msg2_valid", 64'(bus.msg2_valid), 0);
            chk("row.cnt_held", 64'(bus.wait_cnt), 64'(vecs[r].exp_cnt));
        end

        // Stray, wrong-type and duplicate acks; beats into RESP are not consumed
        tg = 26'h0123456;
        sb_q.push_back('{DONE, 6'd9, tg});
        do_start(64'h180, tg, 6'd9);
        send_msg3(ACK, 6'd7, tg ^ 26'h1);
        chk("stray.tag.pulse", 64'(bus.stray_ack), 1);
        chk("stray.tag.pend", bus.pending_list, 64'h180);
        send_msg3(8'h16, 6'd7, tg);
        chk("stray.type.pulse", 64'(bus.stray_ack), 1);
        chk("stray.type.pend", bus.pending_list, 64'h180);
        send_msg3(ACK, 6'd7, tg);
        chk("stray.match.pulse", 64'(bus.stray_ack), 0);
        chk("stray.match.pend", bus.pending_list, 64'h100);
        send_msg3(ACK, 6'd7, tg);
        chk("stray.dup.pulse", 64'(bus.stray_ack), 1);
        chk("stray.dup.pend", bus.pending_list, 64'h100);
        tick();
        chk("stray.pulse_end", 64'(bus.stray_ack), 0);
        bus.msg2_ready = 1'b0;
        send_msg3(ACK, 6'd8, tg);
        chk("stray.last.state", 64'(bus.cur_msg_state), 2);
        chk("stray.last.cnt", 64'(bus.wait_cnt), 7);
        send_msg3(ACK, 6'd8, tg);
        chk("stray.resp_beat.pulse", 64'(bus.stray_ack), 0);
        chk("stray.resp.cnt_frozen", 64'(bus.wait_cnt), 7);
        bus.msg2_ready = 1'b1;
        tick();
        chk("stray.done.state", 64'(bus.cur_msg_state), 0);

        // Completion backpressure while a second start is offered
        tg = 26'h2468ACE;
        bus.msg2_ready = 1'b0;
        sb_q.push_back('{DONE, 6'd17, tg});
        do_start(64'h4, tg, 6'd17);
        send_msg3(ACK, 6'd2, tg);
        bus.start_valid      = 1'b1;
        bus.start_share_list = 64'hFF;
        bus.start_tag        = 26'h1111111;
        bus.start_src        = 6'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.msg2_valid", 64'(bus.msg2_valid), 1);
            chk("bp.msg2_type", 64'(bus.msg2_type), 64'(DONE));
            chk("bp.msg2_dest", 64'(bus.msg2_dest), 17);
            chk("bp.msg2_tag", 64'(bus.msg2_tag), 64'(tg));
            chk("bp.start_ready", 64'(bus.start_ready), 0);
        end
        bus.start_valid = 1'b0;
        bus.msg2_ready  = 1'b1;
        tick();
        chk("bp.after.start_ready", 64'(bus.start_ready), 1);
        chk("bp.after.pend", bus.pending_list, 0);
        chk("bp.after.tag_kept", 64'(bus.msg2_tag), 64'(tg));

`ifdef L2_INV_TIMEOUT_EN
        // Round with a missing sharer times out at wait_cnt 200
        tg = 26'h0F0F0F0;
        bus.msg2_ready = 1'b0;
        sb_q.push_back('{ERR, 6'd12, tg});
        do_start(64'h6, tg, 6'd12);
        send_msg3(ACK, 6'd1, tg);
        chk("tmo.pend_after_ack", bus.pending_list, 64'h4);
        for (int i = 0; i < 400 && bus.cur_msg_state == 2'd1; i++) begin
            chk("tmo.no_early_pulse", 64'(bus.timeout), 0);
            tick();
        end
        chk("tmo.resp_state", 64'(bus.cur_msg_state), 2);
        chk("tmo.pulse", 64'(bus.timeout), 1);
        chk("tmo.type", 64'(bus.msg2_type), 64'(ERR));
        chk("tmo.pend", bus.pending_list, 64'h4);
        chk("tmo.cnt", 64'(bus.wait_cnt), 200);
        tick();
        chk("tmo.pulse_end", 64'(bus.timeout), 0);
        bus.msg2_ready = 1'b1;
        tick();
        chk("tmo.cache_invalid", 64'(bus.cache_state), 0);
        chk("tmo.idle", 64'(bus.cur_msg_state), 0);
`endif

        // Long wait without acks, then reset aborts the round
        do_start(64'h1, 26'h3C3C3C3, 6'd4);
        repeat (SAT_CYC) tick();
        chk("sat.state", 64'(bus.cur_msg_state), 1);
        chk("sat.pend", bus.pending_list, 64'h1);
        chk("sat.timeout_low", 64'(bus.timeout), 0);
`ifndef L2_INV_TIMEOUT_EN
        chk("sat.cnt", 64'(bus.wait_cnt), 255);
`endif
        #2 rst = 1'b0;
        #1;
        chk_all_zero("abort");
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort.release.start_ready", 64'(bus.start_ready), 1);
        tick();
        chk("abort.no_msg2", 64'(bus.msg2_valid), 0);

        chk("sb.empty", 64'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
